// File: rtl/imm_pkg.sv
// imm_pkg: shared definitions for the immediate/format decode stage.
// Contents:
//   fmt_e     - instruction format code as presented on out_fmt.
//   OPC_*     - major opcodes (inst[6:0]) recognised by the decoder.
//   decoded_t - decode record with 64-bit fields. Users that run at
//               XLEN=32 keep only the low XLEN bits.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef struct packed {
    logic [63:0] imm;
    logic [63:0] target;
    fmt_e        fmt;
    logic        illegal;
  } decoded_t;

endpackage

// File: rtl/imm_decode_comb.sv
// imm_decode_comb: purely combinational opcode -> format/immediate/illegal decoder.
// Ports:
//   inst    in  32    instruction word
//   imm     out XLEN  immediate, sign-extended to XLEN (0 for R and illegal)
//   fmt     out 3     instruction format (fmt_e)
//   illegal out 1     unsupported opcode or inst[1:0] != 2'b11
module imm_decode_comb
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  // Classify the opcode; anything unrecognised becomes an illegal R-type.
  always_comb begin
    fmt     = FMT_R;
    illegal = 1'b0;
    if (inst[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (inst[6:0])
        OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: fmt = FMT_I;
        OPC_STORE:          fmt = FMT_S;
        OPC_BRANCH:         fmt = FMT_B;
        OPC_LUI, OPC_AUIPC: fmt = FMT_U;
        OPC_JAL:            fmt = FMT_J;
        OPC_OP:             fmt = FMT_R;
        OPC_OP_IMM_32: begin
          if (XLEN == 64) begin
            fmt = FMT_I;
          end else begin
            illegal = 1'b1;
          end
        end
        OPC_OP_32: begin
          if (XLEN == 64) begin
            fmt = FMT_R;
          end else begin
            illegal = 1'b1;
          end
        end
        default: illegal = 1'b1;
      endcase
    end
  end

  // Assemble the immediate; the signed size cast sign-extends to XLEN.
  // An illegal instruction leaves fmt at FMT_R, so its immediate is 0.
  always_comb begin
    imm = {XLEN{1'b0}};
    case (fmt)
      FMT_I: imm = XLEN'($signed(inst[31:20]));
      FMT_S: imm = XLEN'($signed({inst[31:25], inst[11:7]}));
      FMT_B: imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      FMT_U: imm = XLEN'($signed({inst[31:12], 12'b0}));
      FMT_J: imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      default: imm = {XLEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: registered immediate/format decode stage. It sits behind a
// valid/ready handshake and precomputes the PC-relative target (pc + imm).
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   in_valid/in_ready      upstream handshake
//   in_inst, in_pc         instruction word and its address
//   out_valid/out_ready    downstream handshake
//   out_imm                sign-extended immediate
//   out_fmt                format code (R=0 I=1 S=2 B=3 U=4 J=5)
//   out_target             in_pc + imm, mod 2^XLEN
//   out_illegal            unsupported opcode
// SKID=1 adds a second entry so that in_ready does not depend on out_ready.
// SKID=0 uses a single entry, and in_ready follows out_ready combinationally.
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit SKID = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  logic [XLEN-1:0] dec_imm_s;
  logic [XLEN-1:0] dec_target_s;
  fmt_e            dec_fmt_s;
  logic            dec_ill_s;
  logic            in_fire_s;
  logic            out_fire_s;

  logic            main_valid_r;
  logic [XLEN-1:0] main_imm_r;
  logic [XLEN-1:0] main_target_r;
  fmt_e            main_fmt_r;
  logic            main_ill_r;

  logic            skid_valid_r;
  logic [XLEN-1:0] skid_imm_r;
  logic [XLEN-1:0] skid_target_r;
  fmt_e            skid_fmt_r;
  logic            skid_ill_r;

  imm_decode_comb #(.XLEN(XLEN)) u_dec (
    .inst    (in_inst),
    .imm     (dec_imm_s),
    .fmt     (dec_fmt_s),
    .illegal (dec_ill_s)
  );

  // An illegal instruction has imm = 0, so its target is the pc.
  assign dec_target_s = in_pc + dec_imm_s;

  // Ready logic. The rst term holds in_ready low while reset is applied and
  // lets it rise in the first cycle after rst drops.
  always_comb begin
    in_ready = 1'b0;
    if (SKID) begin
      in_ready = !rst && !skid_valid_r;
    end else begin
      in_ready = !rst && (!main_valid_r || out_ready);
    end
  end

  assign in_fire_s  = in_valid && in_ready;
  assign out_fire_s = main_valid_r && out_ready;

  // Storage entries. Data registers load only on a transfer, so an idle
  // input bus never reaches them.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_r  <= 1'b0;
      main_imm_r    <= {XLEN{1'b0}};
      main_target_r <= {XLEN{1'b0}};
      main_fmt_r    <= FMT_R;
      main_ill_r    <= 1'b0;
      skid_valid_r  <= 1'b0;
      skid_imm_r    <= {XLEN{1'b0}};
      skid_target_r <= {XLEN{1'b0}};
      skid_fmt_r    <= FMT_R;
      skid_ill_r    <= 1'b0;
    end else if (SKID) begin
      if (!main_valid_r || out_fire_s) begin
        // The main entry is free or draining. The older skid entry has
        // priority; in_fire cannot occur while the skid entry is full.
        if (skid_valid_r) begin
          main_valid_r  <= 1'b1;
          main_imm_r    <= skid_imm_r;
          main_target_r <= skid_target_r;
          main_fmt_r    <= skid_fmt_r;
          main_ill_r    <= skid_ill_r;
          skid_valid_r  <= 1'b0;
        end else if (in_fire_s) begin
          main_valid_r  <= 1'b1;
          main_imm_r    <= dec_imm_s;
          main_target_r <= dec_target_s;
          main_fmt_r    <= dec_fmt_s;
          main_ill_r    <= dec_ill_s;
        end else begin
          main_valid_r  <= 1'b0;
        end
      end else if (in_fire_s) begin
        // The output is stalled, so park the new instruction in the skid entry.
        skid_valid_r  <= 1'b1;
        skid_imm_r    <= dec_imm_s;
        skid_target_r <= dec_target_s;
        skid_fmt_r    <= dec_fmt_s;
        skid_ill_r    <= dec_ill_s;
      end
    end else begin
      if (in_fire_s) begin
        main_valid_r  <= 1'b1;
        main_imm_r    <= dec_imm_s;
        main_target_r <= dec_target_s;
        main_fmt_r    <= dec_fmt_s;
        main_ill_r    <= dec_ill_s;
      end else if (out_fire_s) begin
        main_valid_r  <= 1'b0;
      end
    end
  end

  assign out_valid   = main_valid_r;
  assign out_imm     = main_imm_r;
  assign out_target  = main_target_r;
  assign out_fmt     = main_fmt_r;
  assign out_illegal = main_ill_r;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage: table-driven, scoreboarded bench.
// u_a is built with XLEN=32 and SKID=1. u_b is built with XLEN=64 and SKID=0.
module tb_imm_decode_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal;
  logic [31:0] a_in_inst, a_in_pc, a_out_imm, a_out_target;
  logic [2:0]  a_out_fmt;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
  logic [31:0] b_in_inst;
  logic [63:0] b_in_pc, b_out_imm, b_out_target;
  logic [2:0]  b_out_fmt;

  imm_decode_stage #(.XLEN(32), .SKID(1'b1)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inst(a_in_inst), .in_pc(a_in_pc),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_imm(a_out_imm),
    .out_fmt(a_out_fmt), .out_target(a_out_target), .out_illegal(a_out_illegal)
  );

  imm_decode_stage #(.XLEN(64), .SKID(1'b0)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inst(b_in_inst), .in_pc(b_in_pc),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm),
    .out_fmt(b_out_fmt), .out_target(b_out_target), .out_illegal(b_out_illegal)
  );

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [63:0] imm;
    logic [63:0] target;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  vec_t va[14];
  vec_t vb[6];
  exp_t qa[$];
  exp_t qb[$];
  exp_t ez;
  int   total = 0;
  int   bad = 0;

  logic        a_acc, a_pop, a_hold;
  logic [31:0] a_sv_imm, a_sv_tgt;
  logic [2:0]  a_sv_fmt;
  logic        a_sv_ill;
  logic        b_acc, b_pop, b_hold;
  logic [63:0] b_sv_imm, b_sv_tgt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input vec_t v, input bit x64);
    exp_t e;
    logic [63:0] t;
    t = v.pc + v.imm;
    e.imm = v.imm;
    e.fmt = v.fmt;
    e.ill = v.ill;
    e.target = x64 ? t : {32'h0, t[31:0]};
    return e;
  endfunction

  // One cycle on u_a: drive, check held data, score the output, record the input.
  task automatic step_a(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic ordy, input exp_t e);
    exp_t x;
    @(negedge clk);
    a_in_valid = v; a_in_inst = inst; a_in_pc = pc; a_out_ready = ordy;
    #1;
    if (a_hold) begin
      chk("a_stall_valid", {63'h0, a_out_valid}, 64'h1);
      chk("a_stall_imm", {32'h0, a_out_imm}, {32'h0, a_sv_imm});
      chk("a_stall_target", {32'h0, a_out_target}, {32'h0, a_sv_tgt});
      chk("a_stall_fmt_ill", {60'h0, a_out_fmt, a_out_illegal}, {60'h0, a_sv_fmt, a_sv_ill});
    end
    a_hold = a_out_valid && !a_out_ready;
    a_sv_imm = a_out_imm; a_sv_tgt = a_out_target; a_sv_fmt = a_out_fmt; a_sv_ill = a_out_illegal;
    a_pop = a_out_valid && a_out_ready;
    if (a_pop) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected_output: got imm %h target %h, required no output", a_out_imm, a_out_target);
      end else begin
        x = qa.pop_front();
        chk("a_imm", {32'h0, a_out_imm}, x.imm);
        chk("a_target", {32'h0, a_out_target}, x.target);
        chk("a_fmt", {61'h0, a_out_fmt}, {61'h0, x.fmt});
        chk("a_illegal", {63'h0, a_out_illegal}, {63'h0, x.ill});
      end
    end
    a_acc = a_in_valid && a_in_ready;
    if (a_acc) qa.push_back(e);
  endtask

  // One cycle on u_b. This also checks the combinational ready of the single-entry variant.
  task automatic step_b(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                        input logic ordy, input exp_t e);
    exp_t x;
    @(negedge clk);
    b_in_valid = v; b_in_inst = inst; b_in_pc = pc; b_out_ready = ordy;
    #1;
    chk("b_in_ready_comb", {63'h0, b_in_ready}, {63'h0, (!b_out_valid || b_out_ready)});
    if (b_hold) begin
      chk("b_stall_imm", b_out_imm, b_sv_imm);
      chk("b_stall_target", b_out_target, b_sv_tgt);
    end
    b_hold = b_out_valid && !b_out_ready;
    b_sv_imm = b_out_imm; b_sv_tgt = b_out_target;
    b_pop = b_out_valid && b_out_ready;
    if (b_pop) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected_output: got imm %h, required no output", b_out_imm);
      end else begin
        x = qb.pop_front();
        chk("b_imm", b_out_imm, x.imm);
        chk("b_target", b_out_target, x.target);
        chk("b_fmt", {61'h0, b_out_fmt}, {61'h0, x.fmt});
        chk("b_illegal", {63'h0, b_out_illegal}, {63'h0, x.ill});
      end
    end
    b_acc = b_in_valid && b_in_ready;
    if (b_acc) qb.push_back(e);
  endtask

  task automatic feed_a(input int i, input bit rnd);
    int n = 0;
    do begin
      step_a(1'b1, va[i].inst, va[i].pc[31:0], rnd ? 1'($urandom_range(0, 1)) : 1'b1, mk(va[i], 1'b0));
      n++;
    end while (!a_acc && n < 50);
    if (!a_acc) begin
      total++; bad++;
      $display("FAIL a_accept_timeout: vector %0d not accepted in 50 cycles", i);
    end
  endtask

  task automatic feed_b(input int i, input bit rnd);
    int n = 0;
    do begin
      step_b(1'b1, vb[i].inst, vb[i].pc, rnd ? 1'($urandom_range(0, 1)) : 1'b1, mk(vb[i], 1'b1));
      n++;
    end while (!b_acc && n < 50);
    if (!b_acc) begin
      total++; bad++;
      $display("FAIL b_accept_timeout: vector %0d not accepted in 50 cycles", i);
    end
  endtask

  task automatic drain_a();
    int n = 0;
    do begin
      step_a(1'b0, 32'h0, 32'h0, 1'b1, ez);
      n++;
    end while ((qa.size() != 0 || a_out_valid) && n < 30);
    chk("a_drain_empty", qa.size(), 64'h0);
  endtask

  task automatic drain_b();
    int n = 0;
    do begin
      step_b(1'b0, 32'h0, 64'h0, 1'b1, ez);
      n++;
    end while ((qb.size() != 0 || b_out_valid) && n < 30);
    chk("b_drain_empty", qb.size(), 64'h0);
  endtask

  initial begin
    int acc_cnt;
    int idx;
    ez = '{imm: 64'h0, target: 64'h0, fmt: 3'd0, ill: 1'b0};
    va[0]  = '{32'hFFF00093, 64'h0,        64'hFFFFFFFF, 3'd1, 1'b0};
    va[1]  = '{32'hFE112E23, 64'h200,      64'hFFFFFFFC, 3'd2, 1'b0};
    va[2]  = '{32'hFE000CE3, 64'h100,      64'hFFFFFFF8, 3'd3, 1'b0};
    va[3]  = '{32'h00000000, 64'h44,       64'h0,        3'd0, 1'b1};
    va[4]  = '{32'h0000001B, 64'h8,        64'h0,        3'd0, 1'b1};
    va[5]  = '{32'h00000033, 64'h10,       64'h0,        3'd0, 1'b0};
    va[6]  = '{32'h12345017, 64'h1000,     64'h12345000, 3'd4, 1'b0};
    va[7]  = '{32'h0080006F, 64'h20,       64'h8,        3'd5, 1'b0};
    va[8]  = '{32'hFFDFF06F, 64'h30,       64'hFFFFFFFC, 3'd5, 1'b0};
    va[9]  = '{32'h00000010, 64'h50,       64'h0,        3'd0, 1'b1};
    va[10] = '{32'h00008067, 64'h60,       64'h0,        3'd1, 1'b0};
    va[11] = '{32'h00412083, 64'h70,       64'h4,        3'd1, 1'b0};
    va[12] = '{32'h00000073, 64'h80,       64'h0,        3'd1, 1'b0};
    va[13] = '{32'h7FF00093, 64'hFFFFFFF0, 64'h7FF,      3'd1, 1'b0};
    vb[0]  = '{32'h800002B7, 64'h1000, 64'hFFFFFFFF80000000, 3'd4, 1'b0};
    vb[1]  = '{32'h123452B7, 64'h0,    64'h0000000012345000, 3'd4, 1'b0};
    vb[2]  = '{32'hFFF0009B, 64'h10,   64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
    vb[3]  = '{32'h0000003B, 64'h20,   64'h0,                3'd0, 1'b0};
    vb[4]  = '{32'h00000000, 64'hDEAD000000000000, 64'h0,    3'd0, 1'b1};
    vb[5]  = '{32'hFE000CE3, 64'h100,  64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0};

    rst = 1'b1;
    a_in_valid = 1'b0; a_in_inst = 32'h0; a_in_pc = 32'h0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_inst = 32'h0; b_in_pc = 64'h0; b_out_ready = 1'b0;
    a_hold = 1'b0; b_hold = 1'b0; a_acc = 1'b0; a_pop = 1'b0; b_acc = 1'b0; b_pop = 1'b0;
    a_sv_imm = 32'h0; a_sv_tgt = 32'h0; a_sv_fmt = 3'd0; a_sv_ill = 1'b0;
    b_sv_imm = 64'h0; b_sv_tgt = 64'h0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_a_out_valid", {63'h0, a_out_valid}, 64'h0);
    chk("rst_a_in_ready", {63'h0, a_in_ready}, 64'h0);
    chk("rst_a_data", {a_out_imm, a_out_target}, 64'h0);
    chk("rst_a_fmt_ill", {60'h0, a_out_fmt, a_out_illegal}, 64'h0);
    chk("rst_b_out_valid", {63'h0, b_out_valid}, 64'h0);
    chk("rst_b_in_ready", {63'h0, b_in_ready}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_a_in_ready", {63'h0, a_in_ready}, 64'h1);
    chk("post_rst_b_in_ready", {63'h0, b_in_ready}, 64'h1);

    // Latency: output valid exactly one cycle after the accept, then gone
    step_a(1'b1, va[0].inst, va[0].pc[31:0], 1'b1, mk(va[0], 1'b0));
    chk("a_first_accept", {63'h0, a_acc}, 64'h1);
    step_a(1'b0, 32'h0, 32'h0, 1'b1, ez);
    chk("a_latency_1", {63'h0, a_pop}, 64'h1);
    step_a(1'b0, 32'h0, 32'h0, 1'b1, ez);
    chk("a_single_output", {63'h0, a_out_valid}, 64'h0);

    // Full table streamed at full rate, then under random backpressure
    for (int i = 0; i < 14; i++) feed_a(i, 1'b0);
    drain_a();
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 14; i++) feed_a(i, 1'b1);
    drain_a();

    // Stall: four offered with out_ready low, only two fit
    acc_cnt = 0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      step_a(1'b1, va[idx].inst, va[idx].pc[31:0], 1'b0, mk(va[idx], 1'b0));
      if (a_acc) begin
        acc_cnt++;
        idx++;
      end else if (acc_cnt == 2) begin
        chk("a_in_ready_low_when_full", {63'h0, a_in_ready}, 64'h0);
      end
    end
    chk("a_stall_accept_count", acc_cnt, 64'h2);
    // Release: the remaining two enter, and four outputs follow back to back
    for (int c = 0; c < 4; c++) begin
      step_a(idx < 4, va[idx].inst, va[idx].pc[31:0], 1'b1, mk(va[idx], 1'b0));
      if (a_acc) idx++;
      chk("a_no_gap", {63'h0, a_pop}, 64'h1);
    end
    drain_a();
    chk("a_all_four_accepted", idx, 64'h4);

    // Mid-operation reset with both entries full
    step_a(1'b1, va[5].inst, va[5].pc[31:0], 1'b0, mk(va[5], 1'b0));
    step_a(1'b1, va[6].inst, va[6].pc[31:0], 1'b0, mk(va[6], 1'b0));
    step_a(1'b0, 32'h0, 32'h0, 1'b0, ez);
    chk("a_full_before_rst", {62'h0, a_out_valid, a_in_ready}, 64'h2);
    @(negedge clk);
    rst = 1'b1;
    a_in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("a_rst_out_valid", {63'h0, a_out_valid}, 64'h0);
    chk("a_rst_in_ready", {63'h0, a_in_ready}, 64'h0);
    rst = 1'b0;
    #1;
    chk("a_after_rst_in_ready", {63'h0, a_in_ready}, 64'h1);
    qa.delete();
    a_hold = 1'b0;
    b_hold = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step_a(1'b0, 32'h0, 32'h0, 1'b1, ez);
      chk("a_no_stale_output", {63'h0, a_out_valid}, 64'h0);
    end

    // XLEN=64 with a single entry
    for (int i = 0; i < 6; i++) feed_b(i, 1'b0);
    drain_b();
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < 6; i++) feed_b(i, 1'b1);
    drain_b();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
